// File: rtl/rand_frame_checker.sv
// Frame checker for the xorshift random stream: verifies each word against
// the successor of the previous one and reports a per-frame XOR checksum.
module rand_frame_checker #(
    parameter int FRAME_LEN = 256,
    parameter int SHA       = 13,
    parameter int SHB       = 17,
    parameter int SHC       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_sum,
    output logic [8:0]  out_err,
    output logic        busy
);

    localparam int CW = $clog2(FRAME_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        REPORT
    } state_t;

    state_t        state;
    logic [31:0]   prev;
    logic [31:0]   sum;
    logic [8:0]    err;
    logic [CW-1:0] cnt;

    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] succ;
    logic        mis;
    logic [8:0]  err_nxt;
    logic        last;

    always_comb begin
        t1      = prev ^ (prev << SHA);
        t2      = t1 ^ (t1 >> SHB);
        succ    = t2 ^ (t2 << SHC);
        mis     = (in_data != succ);
        err_nxt = err + {8'd0, mis};
        last    = (cnt == CW'(FRAME_LEN - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_err   <= '0;
            busy      <= 1'b0;
            prev      <= '0;
            sum       <= '0;
            err       <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_err   <= '0;
            unique case (state)
                IDLE, REPORT: begin
                    // A word arriving in the report cycle opens the next frame
                    if (in_valid) begin
                        prev  <= in_data;
                        sum   <= in_data;
                        err   <= '0;
                        cnt   <= CW'(1);
                        state <= COLLECT;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        prev <= in_data;
                        sum  <= sum ^ in_data;
                        err  <= err_nxt;
                        cnt  <= cnt + CW'(1);
                        if (last) begin
                            state     <= REPORT;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= sum ^ in_data;
                            out_err   <= err_nxt;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_frame_checker.sv
// Scoreboard bench for rand_frame_checker: stimulus feeds a frame-level model,
// a negedge monitor compares every report against the queued expectation.
module tb_rand_frame_checker;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic [31:0] out_sum;
    logic [8:0]  out_err;
    logic        busy;

    rand_frame_checker #(
        .FRAME_LEN(N), .SHA(13), .SHB(17), .SHC(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_sum(out_sum),
        .out_err(out_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sum;
        logic [8:0]  err;
        int          at;
    } rep_t;

    rep_t        expq[$];
    logic [31:0] cur[$];
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference successor computed in wide arithmetic with explicit masking
    function automatic logic [31:0] xs_m(input logic [31:0] x);
        logic [63:0] v;
        v = {32'd0, x};
        v = (v ^ (v << 13)) & 64'hFFFF_FFFF;
        v = (v ^ (v >> 17)) & 64'hFFFF_FFFF;
        v = (v ^ (v << 5)) & 64'hFFFF_FFFF;
        return v[31:0];
    endfunction

    task automatic model_word(input logic [31:0] w);
        rep_t r;
        cur.push_back(w);
        if (cur.size() == N) begin
            r.sum = '0;
            r.err = '0;
            foreach (cur[i]) begin
                r.sum ^= cur[i];
                if (i > 0 && cur[i] != xs_m(cur[i-1])) r.err++;
            end
            r.at = cyc;
            expq.push_back(r);
            cur.delete();
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (v) model_word(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cur.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out", {23'd0, out_sum, out_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic golden(input logic [31:0] seed, input int sub_idx,
                          input logic [31:0] sub_val, input int max_gap);
        logic [31:0] g;
        logic [31:0] w;
        g = seed;
        for (int i = 0; i < N; i++) begin
            w = (i == sub_idx) ? sub_val : g;
            repeat ($urandom_range(max_gap)) drive(1'b0, '0);
            drive(1'b1, w);
            g = xs_m(g);
        end
    endtask

    always @(negedge clk) begin
        rep_t r;
        if (rst_n) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_report: sum %0h err %0d",
                             out_sum, out_err);
                end else begin
                    r = expq.pop_front();
                    chk("rep_sum", {32'd0, out_sum}, {32'd0, r.sum});
                    chk("rep_err", {55'd0, out_err}, {55'd0, r.err});
                    chk("rep_time", 64'(cyc), 64'(r.at));
                end
            end else begin
                chk("idle_zero", {23'd0, out_sum, out_err}, 64'd0);
            end
        end
    end

    initial begin
        logic [31:0] s;

        // 1: all zeros, with busy tracking
        do_reset();
        chk("busy_pre", {63'd0, busy}, 64'd0);
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 32'd0);
            chk("busy_t1", {63'd0, busy}, {63'd0, (i < N - 1)});
        end
        drive(1'b0, '0);
        chk("busy_after", {63'd0, busy}, 64'd0);

        // 2: constant ones, every check fails
        do_reset();
        for (int i = 0; i < N; i++) drive(1'b1, 32'd1);
        drive(1'b0, '0);

        // 3: golden chain from 1 with random gaps
        do_reset();
        golden(32'd1, -1, '0, 5);
        drive(1'b0, '0);

        // 4: golden chain with a corrupt word
        do_reset();
        golden(32'd1, 100, 32'hDEADBEEF, 2);
        drive(1'b0, '0);

        // 5: two random frames with no gaps at all
        do_reset();
        s = $urandom() | 32'd1;
        golden(s, -1, '0, 0);
        s = $urandom() | 32'd1;
        golden(s, $urandom_range(N - 1), $urandom(), 0);
        drive(1'b0, '0);

        // 6: async reset mid-frame discards the partial frame
        do_reset();
        for (int i = 0; i < 130; i++) drive(1'b1, $urandom());
        #2;
        rst_n = 1'b0;
        cur.delete();
        #1;
        chk("async_busy", {63'd0, busy}, 64'd0);
        chk("async_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) drive(1'b1, 32'd0);

        repeat (5) drive(1'b0, '0);
        checks++;
        if (expq.size() == 0) passes++;
        else $display("FAIL missing_report: got %0d pending expected 0",
                      expq.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rand_frame_checker.md
Name: rand_frame_checker

Overview:
- Single-clock consumer that sits directly downstream of the clk3 FIFO-reader stage, taking its out_valid/rand_num stream.
- Groups incoming words into frames of FRAME_LEN, one frame per seed.
- Checks each word against the xorshift successor of the previous word, and accumulates an XOR checksum.
- Emits a one-cycle report (checksum, mismatch count) per completed frame.

Parameters:
FRAME_LEN, 256, words per frame (>=2)
SHA, 13, first left-shift amount of xorshift
SHB, 17, right-shift amount of xorshift
SHC, 5, second left-shift amount of xorshift

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data valid this cycle; no backpressure, every valid word is accepted
in_data  input  32  random number from upstream stage
out_valid  output  1  one-cycle frame report strobe
out_sum  output  32  XOR of all FRAME_LEN words of the frame
out_err  output  9  count of words not equal to xs(previous word)
busy  output  1  high while a frame is partially collected (COLLECT state)

Behaviour:
- Reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
  - All state clears when rst_n is low: state=IDLE, out_valid=0, out_sum=0, out_err=0, busy=0, prev=0, sum=0, err=0, cnt=0.
  - Reset mid-frame discards the partial frame; no report is produced.
- xs(x), 32-bit, each step truncated to 32 bits:
  - t1 = x ^ (x << SHA)
  - t2 = t1 ^ (t1 >> SHB)
  - xs = t2 ^ (t2 << SHC)
  - Purely combinational off register prev.
- cnt is $clog2(FRAME_LEN)+1 bits wide and counts words accepted in the current frame.
- State IDLE (busy=0):
  - On in_valid: prev<=in_data, sum<=in_data, err<=0, cnt<=1, go to COLLECT.
  - The first word of a frame is never checked.
- State COLLECT (busy=1):
  - On in_valid:
    - err<=err+(in_data!=xs(prev)).
    - prev<=in_data. The check resyncs on actual data, so a single corrupt word costs at most 2 errors.
    - sum<=sum^in_data; cnt<=cnt+1.
  - If this word is the FRAME_LEN-th (cnt==FRAME_LEN-1 before the increment), go to REPORT.
  - Without in_valid: hold. Gaps of any length are allowed; there is no timeout.
- State REPORT, exactly 1 cycle:
  - out_valid=1, out_sum=sum, out_err=err. Outputs are registered, so the report follows the last word by 1 cycle.
  - If in_valid is high in this cycle, the word is taken as the first word of the next frame (same actions as IDLE) and the next state is COLLECT. Otherwise the next state is IDLE.
  - No word is ever dropped.
- out_sum and out_err are 0 whenever out_valid=0.
- err maximum is FRAME_LEN-1 = 255, which fits in 9 bits; no saturation logic is needed.
- Back-to-back words every cycle must be sustained indefinitely, including across frame boundaries.

Test Plan:
1. Reset, then 256 consecutive in_data=0x00000000 (xs(0)=0) -> one out_valid pulse 1 cycle after word 256, out_sum=0, out_err=0. busy high from the cycle after word 1 until the REPORT cycle.
2. Reset, then 256 words each =0x00000001. Expected successor xs(1)=0x00042021, so every check fails -> out_sum=0x00000000, out_err=255.
3. Golden stream: word0=0x00000001, word1=0x00042021, then each subsequent word = xs(previous) per a bench model, with random 0-5 cycle gaps -> out_err=0, out_sum equals the model's XOR fold, exactly one pulse.
4. Golden stream with word 100 replaced by 0xDEADBEEF -> out_err=2 (word 100 and word 101 mismatch); out_sum equals the model fold with the substitution.
5. Two frames back-to-back with in_valid high in the REPORT cycle -> second frame's first word accepted and two pulses observed, 256 words apart. Second report matches its own model with no cross-frame contamination.
6. Assert rst_n low asynchronously after word 130 mid-frame; release and send 256 zeros -> no report for the partial frame, then a single report with out_sum=0, out_err=0.
